booth_div: RTL and testbench

- Sequential signed divider, the inverse of the team's radix-2 Booth multiplier. Same start/busy handshake style.
- Computes x / y over WIDTH-bit two's-complement operands, one quotient bit per clock, using restoring division on magnitudes followed by a sign-fix step.
- Sits beside the multiplier in the lab ALU datapath. Results are held until the next accepted start.

---
 rtl/booth_pkg.sv | 21 ++
 rtl/div_step.sv | 21 ++
 rtl/booth_div.sv | 134 +++++++++++++
 tb/tb_booth_div.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the sequential Booth multiplier/divider pair: FSM states,
// counter sizing and the two's-complement minimum value helper.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Width of the per-bit step counter; never narrower than one bit.
    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    // Most negative two's-complement value of a w-bit word (w <= 64), zero-extended.
    function automatic logic [63:0] min_val(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor magnitude, keep or restore.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0] i_rem,
    input  logic           i_dvd_msb,
    input  logic [WIDTH:0] i_dsr,
    output logic [WIDTH:0] o_rem,
    output logic           o_q_bit
);

    logic [WIDTH:0] w_shift;

    assign w_shift = {i_rem[WIDTH-1:0], i_dvd_msb};

    // A set top remainder bit means the shifted value already exceeds any divisor.
    assign o_q_bit = i_rem[WIDTH] | (w_shift >= i_dsr);
    assign o_rem   = o_q_bit ? (w_shift - i_dsr) : w_shift;

endmodule

// File: rtl/booth_div.sv
// Sequential signed divider: restoring division on magnitudes, one quotient bit
// per clock, then a sign-fix cycle. Define BOOTH_DIV_ERR_EN to add the err output.
module booth_div
    import booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done
`ifdef BOOTH_DIV_ERR_EN
    ,
    output logic             err
`endif
);

    localparam int               CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN  = WIDTH'(min_val(WIDTH));

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH:0]   r_absy;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_zero;
    logic             r_ovf;

    logic [WIDTH-1:0] w_absx;
    logic [WIDTH-1:0] w_absy;
    logic [WIDTH:0]   w_rem_nxt;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    // An unsigned WIDTH-bit magnitude holds |MIN| exactly; the remainder path is WIDTH+1 bits.
    assign w_absx = x[WIDTH-1] ? ({WIDTH{1'b0}} - x) : x;
    assign w_absy = y[WIDTH-1] ? ({WIDTH{1'b0}} - y) : y;

    assign w_q_fix = r_sign_q ? ({WIDTH{1'b0}} - r_dvd) : r_dvd;
    assign w_r_fix = r_sign_r ? ({WIDTH{1'b0}} - r_rem[WIDTH-1:0]) : r_rem[WIDTH-1:0];

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_rem    (r_rem),
        .i_dvd_msb(r_dvd[WIDTH-1]),
        .i_dsr    (r_absy),
        .o_rem    (w_rem_nxt),
        .o_q_bit  (w_q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_dvd    <= '0;
            r_absy   <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            q        <= '0;
            r        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef BOOTH_DIV_ERR_EN
            err      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_dvd    <= w_absx;
                        r_absy   <= {1'b0, w_absy};
                        r_sign_q <= x[WIDTH-1] ^ y[WIDTH-1];
                        r_sign_r <= x[WIDTH-1];
                        r_zero   <= (y == {WIDTH{1'b0}});
                        r_ovf    <= (x == MIN) && (y == {WIDTH{1'b1}});
                        r_rem    <= '0;
                        r_cnt    <= '0;
                        busy     <= 1'b1;
                        r_state  <= CALC;
`ifdef BOOTH_DIV_ERR_EN
                        err      <= 1'b0;
`endif
                    end
                end
                CALC: begin
                    // Quotient bits shift in behind the dividend bits as they are consumed.
                    r_rem <= w_rem_nxt;
                    r_dvd <= {r_dvd[WIDTH-2:0], w_q_bit};
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    if (r_ovf) begin
                        q <= MIN;
                        r <= '0;
                    end else if (r_zero) begin
                        // Dividing by zero leaves |x| in the remainder, so the sign fix returns x.
                        q <= {WIDTH{1'b1}};
                        r <= w_r_fix;
                    end else begin
                        q <= w_q_fix;
                        r <= w_r_fix;
                    end
`ifdef BOOTH_DIV_ERR_EN
                    err     <= r_zero | r_ovf;
`endif
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_div.sv
// Self-checking bench for booth_div: directed corner cases, ignored/back-to-back
// starts, mid-operation reset and a random signed sweep against a reference model.
module tb_booth_div;

    localparam int W = 16;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] x     = '0;
    logic [W-1:0] y     = '0;
    logic         start = 1'b0;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         busy;
    logic         done;
`ifdef BOOTH_DIV_ERR_EN
    logic         err;
    logic         exp_err_q[$];
`endif

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    int busy_cnt = 0;

    logic [2*W-1:0] exp_q[$];
    int             acc_q[$];
    logic [2*W-1:0] last_qr = '0;

    booth_div #(
        .WIDTH(W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .x    (x),
        .y    (y),
        .start(start),
        .q    (q),
        .r    (r),
        .busy (busy),
        .done (done)
`ifdef BOOTH_DIV_ERR_EN
        ,
        .err  (err)
`endif
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: truncating signed division, remainder takes the dividend's sign.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        int sa;
        int sb;
        int qq;
        int rr;
        if (b == '0) return {{W{1'b1}}, a};
        sa = int'($signed(a));
        sb = int'($signed(b));
        qq = sa / sb;
        rr = sa % sb;
        return {qq[W-1:0], rr[W-1:0]};
    endfunction

    // Always returns at a falling edge with busy low (or after a timeout check).
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", {31'b0, busy}, 32'd0);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        x     = a;
        y     = b;
        start = 1'b1;
        exp_q.push_back(model(a, b));
`ifdef BOOTH_DIV_ERR_EN
        exp_err_q.push_back((b == '0) || (a == 16'h8000 && b == 16'hFFFF));
`endif
        @(posedge clk);
        #1;
        acc_q.push_back(cyc);
        start = 1'b0;
        x     = W'($urandom_range(0, 65535));
        y     = W'($urandom_range(0, 65535));
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b);
        wait_idle();
        issue(a, b);
    endtask

    // scoreboard / monitor
    always @(negedge clk) begin
        logic [2*W-1:0] e;
        int             a;
        if (rst_n) begin
            if (busy) begin
                check("qr_hold", {q, r}, last_qr);
                busy_cnt++;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("done_unexpected", {31'b0, done}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    check("q", {16'b0, q}, {16'b0, e[2*W-1:W]});
                    check("r", {16'b0, r}, {16'b0, e[W-1:0]});
                    check("busy_at_done", {31'b0, busy}, 32'd0);
                    check("latency", cyc - a, W + 1);
                    check("busy_cycles", busy_cnt, W + 1);
`ifdef BOOTH_DIV_ERR_EN
                    check("err", {31'b0, err}, {31'b0, exp_err_q.pop_front()});
`endif
                end
                busy_cnt = 0;
            end
        end else begin
            busy_cnt = 0;
        end
        last_qr = {q, r};
    end

    initial begin
        // reset
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_q", {16'b0, q}, 32'd0);
        check("rst_r", {16'b0, r}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
`ifdef BOOTH_DIV_ERR_EN
        check("rst_err", {31'b0, err}, 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // directed signs and special cases
        op(16'd100, 16'd7);
        op(W'(-100), 16'd7);
        op(16'd100, W'(-7));
        op(W'(-100), W'(-7));
        op(16'h8000, 16'hFFFF);
        op(16'd1234, 16'd0);
        op(W'(-5), 16'd0);
        op(16'd0, 16'd5);
        op(16'd3, 16'd100);
        op(W'(-3), 16'd100);
        op(16'h8000, 16'd1);
        op(16'h8000, 16'h8000);
        op(16'h7FFF, 16'hFFFF);
        op(16'h7FFF, 16'h8000);

        // start while busy is ignored; next start lands in the done cycle
        op(16'd50, 16'd5);
        repeat (4) @(negedge clk);
        x     = 16'd9;
        y     = 16'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op(16'd9, 16'd3);

        // reset mid-operation abandons it without a done pulse
        op(16'd1000, 16'd3);
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_q", {16'b0, q}, 32'd0);
        check("abort_r", {16'b0, r}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        exp_q.delete();
        acc_q.delete();
`ifdef BOOTH_DIV_ERR_EN
        exp_err_q.delete();
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        op(16'd7, 16'd2);

        // random signed sweep, back-to-back
        for (int i = 0; i < 2000; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = W'($urandom_range(0, 65535));
            if (i % 4 == 0) b = W'($urandom_range(1, 20));
            else if (i % 4 == 1) b = W'(-int'($urandom_range(1, 20)));
            else b = W'($urandom_range(1, 65535));
            op(a, b);
        end

        wait_idle();
        @(negedge clk);
        check("drain", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
